// File: rtl/enc_dec_stage.sv
// Two-stage extended-Hamming (SECDED) decoder for (8,4), (16,11) and (32,26) codes.
// Stage 1 masks the word and forms syndrome/overall parity; stage 2 corrects and classifies.
module enc_dec_stage #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [MAX_INFO_WIDTH-1:0]     info_out,
    output logic [1:0]                    num_of_errors,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          corr_cnt,
    output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

    localparam int W  = MAX_CODEWORD_WIDTH;
    localparam int SW = 5;

    typedef logic [SW-1:0][W-1:0] h_t;

    // Parity-check rows of the active code; unused rows stay zero.
    function automatic h_t h_sel(input logic [1:0] m);
        h_t h;
        h = '0;
        case (m)
            2'b00: begin
                h[0] = W'(32'h0000_00E4);
                h[1] = W'(32'h0000_00D2);
                h[2] = W'(32'h0000_00B1);
            end
            2'b01: begin
                h[0] = W'(32'h0000_FE08);
                h[1] = W'(32'h0000_F1C4);
                h[2] = W'(32'h0000_CDA2);
                h[3] = W'(32'h0000_AB61);
            end
            2'b10: begin
                h[0] = W'(32'hFFFE_0010);
                h[1] = W'(32'hFF01_FC08);
                h[2] = W'(32'hF0F1_E384);
                h[3] = W'(32'hCCCD_9B42);
                h[4] = W'(32'hAAAB_56C1);
            end
            default: h = '0;
        endcase
        return h;
    endfunction

    function automatic logic [W-1:0] len_mask(input logic [1:0] m);
        case (m)
            2'b00:   return W'(32'h0000_00FF);
            2'b01:   return W'(32'h0000_FFFF);
            2'b10:   return W'(32'hFFFF_FFFF);
            default: return '0;
        endcase
    endfunction

    // Handshake: a side transfers when valid && ready; the whole pipe freezes
    // while a result waits at the output, so in_ready is simply !stall.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 1 combinational: mask, syndrome, overall parity.
    h_t          h_in;
    logic [W-1:0]  cw_in;
    logic [SW-1:0] syn_in;
    logic          par_in;

    always_comb begin
        h_in   = h_sel(mod);
        cw_in  = data_in & len_mask(mod);
        syn_in = '0;
        for (int r = 0; r < SW; r++) begin
            syn_in[r] = ^(h_in[r] & cw_in);
        end
        par_in = ^cw_in;
    end

    logic          s1_valid;
    logic [W-1:0]  s1_cw;
    logic [1:0]    s1_mod;
    logic [SW-1:0] s1_syn;
    logic          s1_par;

    // Stage 2 combinational: locate the column equal to the syndrome and classify.
    h_t                      h_s1;
    logic [W-1:0]            flip;
    logic                    hit;
    logic [W-1:0]            ovr_bit;
    logic [W-1:0]            cw_fix;
    logic [1:0]              st_fix;
    logic [MAX_INFO_WIDTH-1:0] info_fix;

    always_comb begin
        h_s1 = h_sel(s1_mod);
        flip = '0;
        hit  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if ({h_s1[4][i], h_s1[3][i], h_s1[2][i], h_s1[1][i], h_s1[0][i]} == s1_syn) begin
                flip[i] = 1'b1;
                hit     = 1'b1;
            end
        end

        case (s1_mod)
            2'b00:   ovr_bit = W'(32'h0000_0008);
            2'b01:   ovr_bit = W'(32'h0000_0010);
            2'b10:   ovr_bit = W'(32'h0000_0020);
            default: ovr_bit = '0;
        endcase

        cw_fix = s1_cw;
        st_fix = 2'b00;
        if (s1_mod == 2'b11) begin
            cw_fix = '0;
            st_fix = 2'b11;
        end else if (s1_syn == '0) begin
            if (s1_par) begin
                cw_fix = s1_cw ^ ovr_bit;
                st_fix = 2'b01;
            end
        end else if (s1_par && hit) begin
            // A nonzero syndrome can only match a real column, never the zero ones.
            cw_fix = s1_cw ^ flip;
            st_fix = 2'b01;
        end else begin
            st_fix = 2'b10;
        end

        info_fix = '0;
        case (s1_mod)
            2'b00:   info_fix[3:0]  = cw_fix[7:4];
            2'b01:   info_fix[10:0] = cw_fix[15:5];
            2'b10:   info_fix[25:0] = cw_fix[31:6];
            default: info_fix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid      <= 1'b0;
            s1_cw         <= '0;
            s1_mod        <= '0;
            s1_syn        <= '0;
            s1_par        <= 1'b0;
            out_valid     <= 1'b0;
            data_out      <= '0;
            info_out      <= '0;
            num_of_errors <= 2'b00;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_cw  <= cw_in;
                s1_mod <= mod;
                s1_syn <= syn_in;
                s1_par <= par_in;
            end
            if (s1_valid) begin
                data_out      <= cw_fix;
                info_out      <= info_fix;
                num_of_errors <= st_fix;
            end
        end
    end

    // Statistics are taken when the consumer actually takes the word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (num_of_errors == 2'b01 && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + CNT_WIDTH'(1);
            end
            if (num_of_errors == 2'b10 && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_enc_dec_stage.sv
// Bench for enc_dec_stage: directed vectors, random SECDED traffic with backpressure,
// counter saturation/clear and mid-stream reset, checked through an expected-result queue.
module tb_enc_dec_stage;

    localparam int CW  = 32;
    localparam int IW  = 26;
    localparam int CNT = 4;
    localparam int EW  = 60;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   data_in = '0;
    logic [1:0]      mod = 2'b00;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   data_out;
    logic [IW-1:0]   info_out;
    logic [1:0]      num_of_errors;
    logic            cnt_clr = 1'b0;
    logic [CNT-1:0]  corr_cnt;
    logic [CNT-1:0]  uncorr_cnt;

    enc_dec_stage #(
        .MAX_CODEWORD_WIDTH(CW),
        .MAX_INFO_WIDTH(IW),
        .CNT_WIDTH(CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .mod(mod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .info_out(info_out),
        .num_of_errors(num_of_errors),
        .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [EW-1:0] exp_q[$];
    logic          has_exp = 1'b0;
    logic [EW-1:0] exp_word = '0;
    int            ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // reference model: a word is decoded by asking which single flip makes it a codeword
    localparam logic [31:0] H_TAB [3][5] = '{
        '{32'h0000_00E4, 32'h0000_00D2, 32'h0000_00B1, 32'h0, 32'h0},
        '{32'h0000_FE08, 32'h0000_F1C4, 32'h0000_CDA2, 32'h0000_AB61, 32'h0},
        '{32'hFFFE_0010, 32'hFF01_FC08, 32'hF0F1_E384, 32'hCCCD_9B42, 32'hAAAB_56C1}
    };

    function automatic logic [31:0] mask_of(input int m);
        if (m == 2) return 32'hFFFF_FFFF;
        if (m == 1) return 32'h0000_FFFF;
        return 32'h0000_00FF;
    endfunction

    function automatic bit is_codeword(input int m, input logic [31:0] c);
        for (int r = 0; r < 5; r++) begin
            if (^(H_TAB[m][r] & c)) return 1'b0;
        end
        return (^c) == 1'b0;
    endfunction

    function automatic logic [EW-1:0] pack(input logic [1:0] st, input logic [25:0] info,
                                           input logic [31:0] d);
        return {st, info, d};
    endfunction

    function automatic logic [EW-1:0] model(input logic [1:0] m, input logic [31:0] d);
        int            mi;
        int            n;
        int            p;
        logic [31:0]   c;
        logic [31:0]   cc;
        logic [31:0]   one;
        logic [31:0]   info;
        logic [1:0]    st;
        if (m == 2'b11) return pack(2'b11, 26'h0, 32'h0);
        mi  = int'(m);
        n   = 8 << mi;
        p   = 4 + mi;
        c   = d & mask_of(mi);
        one = 32'h1;
        cc  = c;
        if (is_codeword(mi, c)) begin
            st = 2'b00;
        end else begin
            st = 2'b10;
            for (int j = 0; j < n; j++) begin
                if (st == 2'b10 && is_codeword(mi, c ^ (one << j))) begin
                    st = 2'b01;
                    cc = c ^ (one << j);
                end
            end
        end
        info = (cc >> p) & ((one << (n - p)) - 32'h1);
        return pack(st, info[25:0], cc);
    endfunction

    function automatic logic [31:0] gen_word(input int m, input int nerr);
        logic [31:0]   mask;
        logic [31:0]   c;
        logic [31:0]   one;
        logic [EW-1:0] e;
        int            n;
        int            p1;
        int            p2;
        if (m == 3) return $urandom;
        n    = 8 << m;
        mask = mask_of(m);
        one  = 32'h1;
        c    = 32'h0;
        for (int t = 0; t < 64; t++) begin
            e = model(2'(m), $urandom & mask);
            if (e[59:58] != 2'b10) begin
                c = e[31:0];
                break;
            end
        end
        p1 = $urandom_range(0, n - 1);
        if (nerr >= 1) c = c ^ (one << p1);
        if (nerr >= 2) begin
            p2 = (p1 + $urandom_range(1, n - 1)) % n;
            c  = c ^ (one << p2);
        end
        return c | ($urandom & ~mask);
    endfunction

    // driver tasks
    task automatic send(input logic [1:0] m, input logic [31:0] d, input logic he,
                        input logic [EW-1:0] ew);
        bit taken;
        in_valid = 1'b1;
        mod      = m;
        data_in  = d;
        has_exp  = he;
        exp_word = ew;
        taken    = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        has_exp  = 1'b0;
    endtask

    task automatic send_rand(input int m, input int nerr);
        send(2'(m), gen_word(m, nerr), 1'b0, '0);
    endtask

    task automatic drain();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_out_valid();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // scoreboard / monitor
    logic          started = 1'b0;
    logic          rst_prev_low = 1'b0;
    logic          hold_pending = 1'b0;
    logic [EW-1:0] held = '0;
    logic          saw_stall = 1'b0;
    logic [CNT-1:0] m_corr = '0;
    logic [CNT-1:0] m_uncorr = '0;
    logic [EW-1:0] got;
    logic [1:0]    acc_st;
    logic          acc_any;

    always @(negedge clk) begin
        acc_any = 1'b0;
        acc_st  = 2'b00;
        if (rst_prev_low) begin
            started = 1'b1;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_data_out", 64'(data_out), 64'd0);
            check("rst_info_out", 64'(info_out), 64'd0);
            check("rst_status", 64'(num_of_errors), 64'd0);
            check("rst_corr_cnt", 64'(corr_cnt), 64'd0);
            check("rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
        end else if (started) begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (hold_pending) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({num_of_errors, info_out, data_out}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got data %0h, expected no output", data_out);
                end else begin
                    got     = exp_q.pop_front();
                    acc_any = 1'b1;
                    acc_st  = got[59:58];
                    check("data_out", 64'(data_out), 64'(got[31:0]));
                    check("info_out", 64'(info_out), 64'(got[57:32]));
                    check("status", 64'(num_of_errors), 64'(got[59:58]));
                end
            end
            check("corr_cnt", 64'(corr_cnt), 64'(m_corr));
            check("uncorr_cnt", 64'(uncorr_cnt), 64'(m_uncorr));
            if (!in_ready) saw_stall = 1'b1;
        end

        hold_pending = rst && out_valid && !out_ready;
        held         = {num_of_errors, info_out, data_out};

        if (!rst) begin
            exp_q.delete();
            m_corr   = '0;
            m_uncorr = '0;
        end else begin
            if (cnt_clr) begin
                m_corr   = '0;
                m_uncorr = '0;
            end else if (acc_any) begin
                if (acc_st == 2'b01 && m_corr != 4'hF) m_corr = m_corr + 4'h1;
                if (acc_st == 2'b10 && m_uncorr != 4'hF) m_uncorr = m_uncorr + 4'h1;
            end
            if (in_valid && in_ready) exp_q.push_back(has_exp ? exp_word : model(mod, data_in));
        end
        rst_prev_low = !rst;
    end

    initial begin
        #300000;
        compared++;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // stimulus
    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ready_mode = 0;

        send(2'b00, 32'h0000_00B1, 1'b1, pack(2'b00, 26'hB, 32'hB1));
        send(2'b00, 32'h0000_00F1, 1'b1, pack(2'b01, 26'hB, 32'hB1));
        send(2'b00, 32'h0000_00F0, 1'b1, pack(2'b10, 26'hF, 32'hF0));
        send(2'b10, 32'h8000_0000, 1'b1, pack(2'b01, 26'h0, 32'h0));
        send(2'b10, 32'h0000_0020, 1'b1, pack(2'b01, 26'h0, 32'h0));
        send(2'b11, 32'h1234_5678, 1'b1, pack(2'b11, 26'h0, 32'h0));
        send(2'b00, 32'hFFFF_FFB1, 1'b1, pack(2'b00, 26'hB, 32'hB1));
        drain();
        check("corr_after_directed", 64'(corr_cnt), 64'd3);
        check("uncorr_after_directed", 64'(uncorr_cnt), 64'd1);

        @(posedge clk);
        #1;
        ready_mode = 2;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand($urandom_range(0, 2), $urandom_range(0, 2));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        drain();
        check("in_ready_dropped", 64'(saw_stall), 64'd1);

        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            send_rand(($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        @(posedge clk);
        #1;
        ready_mode = 0;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) send_rand(0, 1);
        drain();
        check("corr_saturated", 64'(corr_cnt), 64'hF);

        @(posedge clk);
        #1;
        ready_mode = 2;
        send_rand(0, 1);
        wait_out_valid();
        @(posedge clk);
        #1;
        cnt_clr    = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_beats_increment", 64'(corr_cnt), 64'd0);

        ready_mode = 1;
        for (int i = 0; i < 3; i++) send_rand($urandom_range(0, 2), $urandom_range(0, 2));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) send_rand($urandom_range(0, 3), $urandom_range(0, 2));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
